// File: rtl/data_mem_ctrl.sv
// CPU load/store front end for a single-port, one-cycle-latency data memory.
// Byte stores are read-modify-write; misaligned word accesses complete with err and no memory cycle.
module data_mem_ctrl #(
    parameter int ADDR_BITS = 12
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic        size,
    input  logic        uns,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_ena,
    output logic        mem_wea,
    output logic [31:0] mem_addra,
    output logic [31:0] mem_dina,
    input  logic [31:0] mem_douta
);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;

    state_t                 state;
    logic                   we_q;
    logic                   size_q;
    logic                   uns_q;
    logic [ADDR_BITS+1:0]   addr_q;
    logic [7:0]             wbyte_q;

    logic                   misaligned;
    logic [4:0]             lane_ofs;
    logic [7:0]             lane_byte;
    logic [31:0]            load_word;
    logic [31:0]            merged_word;
    logic                   unused_addr_bits;

    // Address bits above the memory window are deliberately dropped (wrap-around).
    assign unused_addr_bits = ^addr[31:ADDR_BITS+2];

    assign misaligned = ~size & (addr[1:0] != 2'b00);
    assign mem_addra  = {{(30-ADDR_BITS){1'b0}}, addr_q[ADDR_BITS+1:2]};
    assign lane_ofs   = {addr_q[1:0], 3'b000};

    always_comb begin
        lane_byte   = mem_douta[lane_ofs +: 8];
        load_word   = mem_douta;
        merged_word = mem_douta;
        merged_word[lane_ofs +: 8] = wbyte_q;
        if (size_q) begin
            load_word = uns_q ? {24'h0, lane_byte} : {{24{lane_byte[7]}}, lane_byte};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ready    <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            rdata    <= 32'h0;
            mem_ena  <= 1'b0;
            mem_wea  <= 1'b0;
            mem_dina <= 32'h0;
            we_q     <= 1'b0;
            size_q   <= 1'b0;
            uns_q    <= 1'b0;
            addr_q   <= '0;
            wbyte_q  <= 8'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        uns_q   <= uns;
                        addr_q  <= addr[ADDR_BITS+1:0];
                        wbyte_q <= wdata[7:0];
                        ready   <= 1'b0;
                        err     <= misaligned;
                        if (misaligned) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= ISSUE;
                            mem_ena  <= 1'b1;
                            mem_wea  <= we & ~size;
                            mem_dina <= wdata;
                        end
                    end
                end
                ISSUE: begin
                    mem_ena <= 1'b0;
                    mem_wea <= 1'b0;
                    if (we_q && !size_q) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    // mem_douta now holds the word read during ISSUE.
                    if (we_q) begin
                        mem_dina <= merged_word;
                        mem_ena  <= 1'b1;
                        mem_wea  <= 1'b1;
                        state    <= WRITE;
                    end else begin
                        rdata <= load_word;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                WRITE: begin
                    mem_ena <= 1'b0;
                    mem_wea <= 1'b0;
                    done    <= 1'b1;
                    state   <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    ready   <= 1'b1;
                    done    <= 1'b0;
                    mem_ena <= 1'b0;
                    mem_wea <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl with a behavioural one-cycle-latency memory.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic        size = 1'b0;
    logic        uns = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        ready, done, err, mem_ena, mem_wea;
    logic [31:0] rdata, mem_addra, mem_dina;
    logic [31:0] mem_douta = 32'h0;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem [0:4095];
    logic [31:0] issue_addr, issue_dina, wr_dina;
    logic        issue_ena, issue_wea, saw_ena, saw_wea, done_err;
    logic [31:0] rdata_before;

    data_mem_ctrl #(.ADDR_BITS(12)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .uns(uns),
        .addr(addr), .wdata(wdata), .ready(ready), .done(done), .rdata(rdata),
        .err(err), .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra),
        .mem_dina(mem_dina), .mem_douta(mem_douta)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_ena) begin
            if (mem_wea) mem[mem_addra[11:0]] <= mem_dina;
            mem_douta <= mem[mem_addra[11:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Runs one access and checks completion latency and err.
    task automatic op(input string tag, input logic w, input logic s, input logic u,
                      input logic [31:0] a, input logic [31:0] d,
                      input int exp_lat, input logic exp_err);
        int lat;
        int waited;
        waited = 0;
        while (!ready && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!ready) chk({tag, "_ready_timeout"}, 32'(ready), 32'd1);
        @(negedge clk);
        req = 1'b1; we = w; size = s; uns = u; addr = a; wdata = d;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; size = 1'b0; uns = 1'b0; addr = 32'hFFFF_FFFF; wdata = 32'h0;
        lat = 0; saw_ena = 1'b0; saw_wea = 1'b0; wr_dina = 32'h0; done_err = 1'b0;
        issue_addr = mem_addra; issue_dina = mem_dina; issue_ena = mem_ena; issue_wea = mem_wea;
        for (int c = 1; c <= 8; c++) begin
            if (mem_ena) saw_ena = 1'b1;
            if (mem_wea) begin
                saw_wea = 1'b1;
                wr_dina = mem_dina;
            end
            if (done) begin
                lat = c;
                done_err = err;
                break;
            end
            @(posedge clk); #1;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_err"}, 32'(done_err), 32'(exp_err));
    endtask

    initial begin
        #12;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_done_err", {30'h0, done, err}, 32'h0);
        chk("rst_mem_en", {30'h0, mem_ena, mem_wea}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_addra", mem_addra, 32'h0);
        chk("rst_dina", mem_dina, 32'h0);
        @(negedge clk); rst_n = 1'b1;

        op("wst", 1, 0, 0, 32'h10, 32'hDEADBEEF, 2, 0);
        chk("wst_issue_addr", issue_addr, 32'h4);
        chk("wst_issue_en", {30'h0, issue_ena, issue_wea}, 32'h3);
        chk("wst_issue_dina", issue_dina, 32'hDEADBEEF);

        op("wld", 0, 0, 0, 32'h10, 32'h0, 3, 0);
        chk("wld_rdata", rdata, 32'hDEADBEEF);
        chk("wld_no_wea", 32'(saw_wea), 32'd0);

        op("wst2", 1, 0, 0, 32'h10, 32'h80FF7F01, 2, 0);
        chk("wst2_keeps_rdata", rdata, 32'hDEADBEEF);
        op("bld3s", 0, 1, 0, 32'h13, 32'h0, 3, 0);
        chk("bld3s_rdata", rdata, 32'hFFFFFF80);
        op("bld3u", 0, 1, 1, 32'h13, 32'h0, 3, 0);
        chk("bld3u_rdata", rdata, 32'h00000080);
        op("bld2s", 0, 1, 0, 32'h12, 32'h0, 3, 0);
        chk("bld2s_rdata", rdata, 32'hFFFFFFFF);
        op("bld1s", 0, 1, 0, 32'h11, 32'h0, 3, 0);
        chk("bld1s_rdata", rdata, 32'h0000007F);
        op("bld0u", 0, 1, 1, 32'h10, 32'h0, 3, 0);
        chk("bld0u_rdata", rdata, 32'h00000001);

        op("wst3", 1, 0, 0, 32'h10, 32'h11223344, 2, 0);
        op("bst", 1, 1, 0, 32'h11, 32'h000000AA, 4, 0);
        chk("bst_write_dina", wr_dina, 32'h1122AA44);
        chk("bst_wea", 32'(saw_wea), 32'd1);
        chk("bst_keeps_rdata", rdata, 32'h00000001);
        op("bst_rd", 0, 0, 0, 32'h10, 32'h0, 3, 0);
        chk("bst_rd_rdata", rdata, 32'h1122AA44);

        rdata_before = rdata;
        op("mis_ld", 0, 0, 0, 32'h22, 32'h0, 1, 1);
        chk("mis_ld_no_ena", 32'(saw_ena), 32'd0);
        chk("mis_ld_rdata", rdata, rdata_before);
        op("mis_st", 1, 0, 0, 32'h23, 32'h12345678, 1, 1);
        chk("mis_st_no_ena", 32'(saw_ena), 32'd0);

        op("wrap_st", 1, 0, 0, 32'h0000_4014, 32'hA5A5_5A5A, 2, 0);
        chk("wrap_addr", issue_addr, 32'h5);
        op("wrap_ld", 0, 0, 0, 32'h14, 32'h0, 3, 0);
        chk("wrap_rdata", rdata, 32'hA5A5_5A5A);

        op("pre_st", 1, 0, 0, 32'h20, 32'hCAFEF00D, 2, 0);
        @(posedge clk); #1;
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 1'b1; addr = 32'h21; wdata = 32'h55;
        @(posedge clk); #1;
        req = 1'b0; we = 1'b0; size = 1'b0;
        chk("abort_issue_ena", 32'(mem_ena), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_mem_en", {30'h0, mem_ena, mem_wea}, 32'h0);
        chk("abort_rdata", rdata, 32'h0);
        @(posedge clk); #1;
        chk("abort_hold_ena", 32'(mem_ena), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        op("abort_rd", 0, 0, 0, 32'h20, 32'h0, 3, 0);
        chk("abort_rd_rdata", rdata, 32'hCAFEF00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
